nand_op_sequencer: RTL and testbench
====================================

# nand_op_sequencer

Multi-cycle logic unit that evaluates any standard 2-input bitwise function by sequencing one shared WIDTH-bit NAND stage. Each cycle it performs one NAND evaluation, writing temporaries back to internal registers. Operands enter and results leave over valid/ready handshakes. It sits between a requester, such as a test sequencer or a small ALU front end, and the `nand_gate` primitive.

## Interface
- `WIDTH`, default 4: operand and result width in bits.
- `Clk` input, 1 bit: sole clock, rising edge.
- `RstN` input, 1 bit: asynchronous reset, active-low.
- `InValid` input, 1 bit: operation request valid.
- `InReady` output, 1 bit: block can accept a request.
- `Op` input, 3 bits: operation code (see Operation).
- `A` input, WIDTH bits: operand A, captured at accept.
- `B` input, WIDTH bits: operand B, captured at accept.
- `OutValid` output, 1 bit: `Result` is valid.
- `OutReady` input, 1 bit: consumer accepts the result.
- `Result` output, WIDTH bits: registered result.
- `ErrOp` output, 1 bit: the current result came from a reserved opcode.

## Operation
- Op codes: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(A), 7 reserved.
- Internal registers: `Ra` and `Rb` hold the captured operands. `T` and `U` hold temporaries.
- One NAND evaluation per EXEC cycle. Notation n(X,Y) means ~(X&Y) per bit.
- Step sequences (s0 first). Operands are register values before the step's clock edge.
  - NAND: R=n(A,B)
  - AND: T=n(A,B); R=n(T,T)
  - OR: T=n(A,A); U=n(B,B); R=n(T,U)
  - NOR: T=n(A,A); U=n(B,B); T=n(T,U); R=n(T,T)
  - XOR: T=n(A,B); U=n(A,T); T=n(B,T); R=n(U,T)
  - XNOR: the first three XOR steps; then T=n(U,T); R=n(T,T)
  - NOT: R=n(A,A)
  - Reserved: 1 step, R=0, ErrOp=1
- Step counts: NAND 1, AND 2, OR 3, NOR 4, XOR 4, XNOR 5, NOT 1, reserved 1.
- FSM states:
  - IDLE: InReady=1. On InValid, capture A, B and Op, clear the step counter, go to EXEC.
  - EXEC: execute step `step`. On the last step, write `Result` and `ErrOp`, go to DONE. Otherwise increment `step`.
  - DONE: OutValid=1. On OutReady, go to IDLE.
- InReady is high only in IDLE. A request arriving while busy is held off; it is never dropped.
- Changes on A, B or Op after accept have no effect.
- In DONE, `Result` and `ErrOp` are stable until the handshake completes.

## Timing
- Reset (async assert, sync release): state IDLE, InReady=1, OutValid=0, Result=0, ErrOp=0, T=U=Ra=Rb=0, step=0.
- Request accepted at edge k, N = step count: OutValid rises after edge k+N.
- Minimum request-to-request period is N+2 cycles (accept, N steps, done handshake). Accept and result handshakes never overlap.
- OutReady may already be high on entry to DONE. The result handshake then completes on the first DONE cycle.
- A reset asserted mid-EXEC or mid-DONE aborts immediately, and the pending result is discarded.

## Configuration
- `NAND_SEQ_STEP_CNT_EN` defined:
  - Adds output `StepCnt` [15:0], the total NAND evaluations since reset.
  - Increments once per EXEC cycle and saturates at 16'hFFFF.
  - Reset value is 0.
  - Reserved-op steps also count.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `nand_seq_pkg` holds:
  - the Op encodings and the reserved code,
  - the state encodings IDLE/EXEC/DONE,
  - the per-op step-count constants,
  - the operand-select codes for the NAND stage inputs (A, B, T, U).
- Sub-module `nand_gate`, reused unchanged: WIDTH instances in a generate loop form the single shared NAND stage. No other NAND logic exists in the block.
- The decode from (op, step) to (X select, Y select, destination T/U/R) is one combinational case block.

## Test plan
- Reset, then check idle outputs: InReady=1, OutValid=0, Result=4'b0000, ErrOp=0.
- WIDTH=4, A=4'b1100, B=4'b1010, OutReady=1, run each op in turn. Required results and cycles from accept to OutValid:
  - NAND 0111, 1 cycle
  - AND 1000, 2 cycles
  - OR 1110, 3 cycles
  - NOR 0001, 4 cycles
  - XOR 0110, 4 cycles
  - XNOR 1001, 5 cycles
  - NOT 0011, 1 cycle
- Backpressure: XNOR with OutReady=0 for 6 cycles.
  - Result stays 4'b1001, OutValid stays high and InReady stays low throughout.
  - Raising OutReady returns the block to IDLE next cycle.
- Busy hold-off and operand isolation:
  - InValid held high with a second request during EXEC: it is accepted only after DONE→IDLE.
  - A and B toggled during EXEC do not alter the first result.
- Reserved Op=7: Result=0000 and ErrOp=1 after 1 cycle. The next valid op clears ErrOp.
- Assert RstN low on step 2 of XOR: all outputs return to reset values immediately with no spurious OutValid. With `NAND_SEQ_STEP_CNT_EN` defined, StepCnt reads 0.

Source files
------------

// File: rtl/nand_seq_pkg.sv
// Shared types and constants for the NAND op sequencer.
// Ops, FSM states, per-op step counts and NAND stage select codes.
package nand_seq_pkg;

  typedef enum logic [2:0] {
    OP_NAND = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] STEPS_NAND = 3'd1;
  localparam logic [2:0] STEPS_AND  = 3'd2;
  localparam logic [2:0] STEPS_OR   = 3'd3;
  localparam logic [2:0] STEPS_NOR  = 3'd4;
  localparam logic [2:0] STEPS_XOR  = 3'd4;
  localparam logic [2:0] STEPS_XNOR = 3'd5;
  localparam logic [2:0] STEPS_NOT  = 3'd1;
  localparam logic [2:0] STEPS_RSV  = 3'd1;

  // NAND stage input selects
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_T = 2'd2;
  localparam logic [1:0] SEL_U = 2'd3;

  // NAND stage destinations
  localparam logic [1:0] DST_T = 2'd0;
  localparam logic [1:0] DST_U = 2'd1;
  localparam logic [1:0] DST_R = 2'd2;

  function automatic logic [2:0] op_steps(op_e op);
    logic [2:0] n;
    n = STEPS_RSV;
    unique case (op)
      OP_NAND: n = STEPS_NAND;
      OP_AND:  n = STEPS_AND;
      OP_OR:   n = STEPS_OR;
      OP_NOR:  n = STEPS_NOR;
      OP_XOR:  n = STEPS_XOR;
      OP_XNOR: n = STEPS_XNOR;
      OP_NOT:  n = STEPS_NOT;
      OP_RSV:  n = STEPS_RSV;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/nand_op_sequencer_nand_gate.sv
// Single-bit 2-input NAND primitive.
// Replicated per bit to form the shared NAND stage.
module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/nand_op_sequencer.sv
// Multi-cycle bitwise logic unit built on one shared NAND stage.
// Optional StepCnt output enabled by NAND_SEQ_STEP_CNT_EN.
module nand_op_sequencer
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
`ifdef NAND_SEQ_STEP_CNT_EN
  output logic [15:0]      StepCnt,
`endif
  output logic             ErrOp
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [2:0]       step_q, step_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
`ifdef NAND_SEQ_STEP_CNT_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  logic [1:0]       sel_x, sel_y, dst;
  logic [WIDTH-1:0] x, y, n;
  logic             last;

  // (op, step) -> {X select, Y select, destination}
  always_comb begin
    {sel_x, sel_y, dst} = {SEL_A, SEL_A, DST_R};
    unique case (op_q)
      OP_NAND: {sel_x, sel_y, dst} = {SEL_A, SEL_B, DST_R};
      OP_AND: begin
        unique case (step_q)
          3'd0:    {sel_x, sel_y, dst} = {SEL_A, SEL_B, DST_T};
          default: {sel_x, sel_y, dst} = {SEL_T, SEL_T, DST_R};
        endcase
      end
      OP_OR: begin
        unique case (step_q)
          3'd0:    {sel_x, sel_y, dst} = {SEL_A, SEL_A, DST_T};
          3'd1:    {sel_x, sel_y, dst} = {SEL_B, SEL_B, DST_U};
          default: {sel_x, sel_y, dst} = {SEL_T, SEL_U, DST_R};
        endcase
      end
      OP_NOR: begin
        unique case (step_q)
          3'd0:    {sel_x, sel_y, dst} = {SEL_A, SEL_A, DST_T};
          3'd1:    {sel_x, sel_y, dst} = {SEL_B, SEL_B, DST_U};
          3'd2:    {sel_x, sel_y, dst} = {SEL_T, SEL_U, DST_T};
          default: {sel_x, sel_y, dst} = {SEL_T, SEL_T, DST_R};
        endcase
      end
      OP_XOR: begin
        unique case (step_q)
          3'd0:    {sel_x, sel_y, dst} = {SEL_A, SEL_B, DST_T};
          3'd1:    {sel_x, sel_y, dst} = {SEL_A, SEL_T, DST_U};
          3'd2:    {sel_x, sel_y, dst} = {SEL_B, SEL_T, DST_T};
          default: {sel_x, sel_y, dst} = {SEL_U, SEL_T, DST_R};
        endcase
      end
      OP_XNOR: begin
        unique case (step_q)
          3'd0:    {sel_x, sel_y, dst} = {SEL_A, SEL_B, DST_T};
          3'd1:    {sel_x, sel_y, dst} = {SEL_A, SEL_T, DST_U};
          3'd2:    {sel_x, sel_y, dst} = {SEL_B, SEL_T, DST_T};
          3'd3:    {sel_x, sel_y, dst} = {SEL_U, SEL_T, DST_T};
          default: {sel_x, sel_y, dst} = {SEL_T, SEL_T, DST_R};
        endcase
      end
      OP_NOT:  {sel_x, sel_y, dst} = {SEL_A, SEL_A, DST_R};
      OP_RSV:  {sel_x, sel_y, dst} = {SEL_A, SEL_A, DST_R};
    endcase
  end

  always_comb begin
    x = ra_q;
    unique case (sel_x)
      SEL_A:   x = ra_q;
      SEL_B:   x = rb_q;
      SEL_T:   x = t_q;
      default: x = u_q;
    endcase
  end

  always_comb begin
    y = ra_q;
    unique case (sel_y)
      SEL_A:   y = ra_q;
      SEL_B:   y = rb_q;
      SEL_T:   y = t_q;
      default: y = u_q;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_nand
    nand_gate u_nand (
      .a(x[i]),
      .b(y[i]),
      .y(n[i])
    );
  end

  assign last = (step_q == op_steps(op_q) - 3'd1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    t_d     = t_q;
    u_d     = u_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (InValid) begin
          ra_d    = A;
          rb_d    = B;
          op_d    = op_e'(Op);
          step_d  = 3'd0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dst == DST_T) t_d = n;
        if (dst == DST_U) u_d = n;
        if (last) begin
          res_d   = (op_q == OP_RSV) ? '0 : n;
          err_d   = (op_q == OP_RSV);
          state_d = S_DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_DONE: begin
        if (OutReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef NAND_SEQ_STEP_CNT_EN
  // Saturating count of NAND evaluations
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_EXEC && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign StepCnt = cnt_q;
`endif

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= S_IDLE;
      op_q    <= OP_NAND;
      step_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      t_q     <= '0;
      u_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      t_q     <= t_d;
      u_q     <= u_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = (state_q == S_DONE);
  assign Result   = res_q;
  assign ErrOp    = err_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Self-checking bench for nand_op_sequencer.
// Vector table plus scoreboard queue and multi-cycle corner sequences.
module tb_nand_op_sequencer;

  logic       Clk = 1'b0;
  logic       RstN = 1'b0;
  logic       InValid = 1'b0;
  logic       OutReady = 1'b0;
  logic [2:0] Op = 3'd0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic       InReady;
  logic       OutValid;
  logic [3:0] Result;
  logic       ErrOp;
`ifdef NAND_SEQ_STEP_CNT_EN
  logic [15:0] StepCnt;
`endif

  nand_op_sequencer #(.WIDTH(4)) dut (
    .Clk(Clk),
    .RstN(RstN),
    .InValid(InValid),
    .InReady(InReady),
    .Op(Op),
    .A(A),
    .B(B),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Result(Result),
`ifdef NAND_SEQ_STEP_CNT_EN
    .StepCnt(StepCnt),
`endif
    .ErrOp(ErrOp)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] r;
    logic       e;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    logic       e;
    int         lat;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[11];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Entered on the falling edge right after the accept edge.
  task automatic wait_out(input string name, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (!OutValid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check({name, " valid"}, 32'(OutValid), 32'd1);
    check({name, " latency"}, lat, exp_lat);
    if (sbq.size() == 0) begin
      check({name, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({name, " result"}, 32'(Result), 32'(e.r));
      check({name, " errop"}, 32'(ErrOp), 32'(e.e));
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] r, input logic e, input int lat);
    exp_t x;
    @(negedge Clk);
    check({name, " inready"}, 32'(InReady), 32'd1);
    InValid = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(posedge Clk);
    x.r = r;
    x.e = e;
    sbq.push_back(x);
    @(negedge Clk);
    InValid = 1'b0;
    A = ~a;
    B = ~b;
    Op = 3'($urandom_range(0, 7));
    wait_out(name, lat);
    if (OutReady) begin
      @(negedge Clk);
      check({name, " back idle"}, 32'({InReady, OutValid}), 32'b10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t x;
    vt[0]  = '{3'd0, 4'b1100, 4'b1010, 4'b0111, 1'b0, 1};
    vt[1]  = '{3'd1, 4'b1100, 4'b1010, 4'b1000, 1'b0, 2};
    vt[2]  = '{3'd2, 4'b1100, 4'b1010, 4'b1110, 1'b0, 3};
    vt[3]  = '{3'd3, 4'b1100, 4'b1010, 4'b0001, 1'b0, 4};
    vt[4]  = '{3'd4, 4'b1100, 4'b1010, 4'b0110, 1'b0, 4};
    vt[5]  = '{3'd5, 4'b1100, 4'b1010, 4'b1001, 1'b0, 5};
    vt[6]  = '{3'd6, 4'b1100, 4'b1010, 4'b0011, 1'b0, 1};
    vt[7]  = '{3'd7, 4'b1100, 4'b1010, 4'b0000, 1'b1, 1};
    vt[8]  = '{3'd0, 4'b1111, 4'b0101, 4'b1010, 1'b0, 1};
    vt[9]  = '{3'd4, 4'b0101, 4'b0011, 4'b0110, 1'b0, 4};
    vt[10] = '{3'd3, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4};

    repeat (2) @(negedge Clk);
    check("reset inready", 32'(InReady), 32'd1);
    check("reset outvalid", 32'(OutValid), 32'd0);
    check("reset result", 32'(Result), 32'd0);
    check("reset errop", 32'(ErrOp), 32'd0);
    RstN = 1'b1;
    OutReady = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
            vt[i].r, vt[i].e, vt[i].lat);
    end

    // Backpressure on an XNOR result
    OutReady = 1'b0;
    do_op("bp", 3'd5, 4'b1100, 4'b1010, 4'b1001, 1'b0, 5);
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      check($sformatf("bp hold%0d", c),
            32'({Result, OutValid, InReady}), 32'({4'b1001, 1'b1, 1'b0}));
    end
    OutReady = 1'b1;
    @(negedge Clk);
    check("bp release", 32'({InReady, OutValid}), 32'b10);

    // Second request held off while busy; operands toggled mid-flight
    @(negedge Clk);
    InValid = 1'b1;
    Op = 3'd4;
    A = 4'b1100;
    B = 4'b1010;
    @(posedge Clk);
    x.r = 4'b0110;
    x.e = 1'b0;
    sbq.push_back(x);
    @(negedge Clk);
    Op = 3'd1;
    A = 4'b0110;
    B = 4'b0011;
    check("busy inready", 32'(InReady), 32'd0);
    wait_out("busy first", 4);
    x.r = 4'b0010;
    x.e = 1'b0;
    sbq.push_back(x);
    @(negedge Clk);
    check("busy idle", 32'({InReady, OutValid}), 32'b10);
    @(negedge Clk);
    InValid = 1'b0;
    check("busy second accepted", 32'(InReady), 32'd0);
    wait_out("busy second", 2);
    @(negedge Clk);

    // Reset during step 2 of XOR
    @(negedge Clk);
    InValid = 1'b1;
    Op = 3'd4;
    A = 4'b1100;
    B = 4'b1010;
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    RstN = 1'b0;
    #1;
    check("abort outputs",
          32'({InReady, OutValid, Result, ErrOp}), 32'({1'b1, 1'b0, 4'b0, 1'b0}));
`ifdef NAND_SEQ_STEP_CNT_EN
    check("abort stepcnt", 32'(StepCnt), 32'd0);
`endif
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check($sformatf("abort quiet%0d", c), 32'(OutValid), 32'd0);
    end
    RstN = 1'b1;
    do_op("after abort", 3'd2, 4'b0100, 4'b0001, 4'b0101, 1'b0, 3);

    check("scoreboard empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
